ripl_threshold_stream: RTL and testbench
========================================

Name: ripl_threshold_stream

Overview:
- Parametrised streaming threshold actor for the RIPL micro-benchmark chain: consumes one pixel per token on In1 and emits one classified pixel per token on Out1.
- Uses the same SEND/ACK/RDY/COUNT token handshake as the other generated actors and sits between a pixel source FIFO and a sink FIFO.
- Adds a one-stage registered pipeline with skid control, selectable threshold mode and a frame-position counter with end-of-frame flag.

Parameters:
- DATA_W, 8, pixel width in bits (1..16)
- THRESH, 128, compare value; pixel >= THRESH is "high"
- MODE, 0, 0 = binary (high -> HI_VAL, low -> LO_VAL); 1 = to-zero (high -> pixel unchanged, low -> 0)
- HI_VAL, 2**DATA_W-1, binary-mode high output
- LO_VAL, 0, binary-mode low output
- FRAME_PIXELS, 65536, tokens per frame; counter wrap point (>= 1)

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- In1_DATA  in  DATA_W  input pixel
- In1_SEND  in  1  upstream token available
- In1_COUNT  in  16  upstream token count (ignored; one token per firing)
- In1_ACK  out  1  token consumed this cycle
- Out1_DATA  out  DATA_W  result pixel
- Out1_SEND  out  1  token written this cycle
- Out1_RDY  in  1  downstream has space for one token
- Out1_ACK  in  1  downstream ack (ignored)
- Out1_COUNT  out  16  tokens per send, constant 16'd1
- Out1_EOF  out  1  qualifies Out1_SEND: last pixel of the frame

Behaviour:
- Reset (async assert, sync release): out_valid=0, Out1_DATA=0, Out1_EOF=0, pix_cnt=0, started=0; In1_ACK=0, Out1_SEND=0.
- started is set on the first clock edge after RESET is released; In1_ACK is held at 0 while started=0, so the earliest ACK occurs in the second cycle after release.
- Fire: In1_ACK = started & In1_SEND & (~out_valid | Out1_RDY). This is combinational and In1_DATA is sampled on the same edge.
- Out1_SEND = out_valid & Out1_RDY. The token leaves on that edge.
- Pipeline register: on a fire, load the result, set out_valid=1 and set EOF = (pix_cnt == FRAME_PIXELS-1). On a send without a fire, clear out_valid. A simultaneous send and fire gives back-to-back transfer at full 1 token/cycle throughput.
- Latency: the token accepted at edge N is presented on Out1_DATA and becomes sendable from cycle N+1.
- Out1_DATA and Out1_EOF hold stable while out_valid=1 and Out1_RDY=0.
- Compare is unsigned and DATA_W wide. HI_VAL and LO_VAL are truncated to DATA_W.
- pix_cnt: width clog2(FRAME_PIXELS) (minimum 1). It increments on each fire and wraps FRAME_PIXELS-1 -> 0. When FRAME_PIXELS=1, every token carries EOF.
- In1_SEND=0 or Out1_RDY=0 stalls produce no state change other than the described hold.
- RESET asserted mid-frame: any in-flight token is dropped, pix_cnt returns to 0 and outputs return to their reset values immediately.

Optional Feature:
- RIPL_RUNTIME_THRESH_EN defined: adds ports Thr_DATA (in, DATA_W), Thr_SEND (in, 1) and Thr_ACK (out, 1).
  - Thr_ACK = started & Thr_SEND whenever the pending register is empty; an accepted value fills pending.
  - Pending is applied to the active threshold on the first fire with pix_cnt==0, i.e. only at a frame start, and pending then empties.
  - Reset loads the active threshold with THRESH and empties pending.
  - A frame-start fire and a Thr accept in the same cycle: the frame uses the old threshold and the new value stays pending.
- Not defined: the threshold is the constant THRESH, the Thr_* ports are absent, and there is no pending register.

Decomposition:
- Package ripl_stream_pkg holds:
  - COUNT_W=16 and UNIT_COUNT=16'd1
  - mode constants MODE_BINARY=0 and MODE_TOZERO=1
  - a clog2 helper function
- One natural sub-module: ripl_frame_counter (count enable, wrap at FRAME_PIXELS, last flag). It is reusable by the other RIPL actors.

Test Plan:
- Reset release with In1_SEND=1 and Out1_RDY=1 -> In1_ACK=0 in the first cycle, ACK from the second cycle; first Out1_SEND one cycle after the first ACK; Out1_COUNT=1.
- Streaming in MODE=0 with inputs 127, 128, 255, 0 and Out1_RDY=1 -> outputs 0, 255, 255, 0 on consecutive cycles, one per clock.
- MODE=1 with inputs 100, 200 -> outputs 0, 200.
- Backpressure: Out1_RDY=0 for 5 cycles while out_valid=1 -> In1_ACK=0, Out1_DATA held; RDY=1 -> send plus a same-cycle refill ACK.
- FRAME_PIXELS=4, stream 9 tokens -> Out1_EOF set on tokens 4 and 8 only.
- RESET asserted mid-frame with out_valid=1 -> Out1_SEND=0 at once; after release, EOF falls on the 4th token again. With RIPL_RUNTIME_THRESH_EN, Thr=50 loaded mid-frame takes effect on the first pixel of the next frame only.

Source files
------------

// File: rtl/ripl_stream_pkg.sv
// Shared constants and helpers for the RIPL streaming actors.
package ripl_stream_pkg;

  localparam int COUNT_W = 16;
  localparam logic [COUNT_W-1:0] UNIT_COUNT = 16'd1;

  localparam int MODE_BINARY = 0;
  localparam int MODE_TOZERO = 1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/ripl_frame_counter.sv
// Frame position counter: advances on en, wraps at FRAME_PIXELS, flags first/last slot.
module ripl_frame_counter
  import ripl_stream_pkg::*;
#(
  parameter int FRAME_PIXELS = 65536
) (
  input  logic CLK,
  input  logic RESET,
  input  logic en,
  output logic first,
  output logic last
);

  localparam int CNT_W = (clog2(FRAME_PIXELS) < 1) ? 1 : clog2(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PIXELS - 1);

  logic [CNT_W-1:0] pix_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pix_cnt <= '0;
    end else if (en) begin
      pix_cnt <= last ? '0 : pix_cnt + CNT_W'(1);
    end
  end

  assign first = (pix_cnt == '0);
  assign last  = (pix_cnt == LAST_CNT);

endmodule

// File: rtl/ripl_threshold_stream.sv
// Streaming threshold actor with one-slot output register and frame EOF tagging.
// Define RIPL_RUNTIME_THRESH_EN to add the Thr_* runtime threshold port.
module ripl_threshold_stream
  import ripl_stream_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int THRESH       = 128,
  parameter int MODE         = 0,
  parameter int HI_VAL       = 2**DATA_W - 1,
  parameter int LO_VAL       = 0,
  parameter int FRAME_PIXELS = 65536
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [DATA_W-1:0]  In1_DATA,
  input  logic               In1_SEND,
  input  logic [COUNT_W-1:0] In1_COUNT,
  output logic               In1_ACK,
  output logic [DATA_W-1:0]  Out1_DATA,
  output logic               Out1_SEND,
  input  logic               Out1_RDY,
  input  logic               Out1_ACK,
  output logic [COUNT_W-1:0] Out1_COUNT,
  output logic               Out1_EOF
`ifdef RIPL_RUNTIME_THRESH_EN
  ,
  input  logic [DATA_W-1:0]  Thr_DATA,
  input  logic               Thr_SEND,
  output logic               Thr_ACK
`endif
);

  localparam logic [DATA_W-1:0] THR_D = DATA_W'(THRESH);
  localparam logic [DATA_W-1:0] HI_D  = DATA_W'(HI_VAL);
  localparam logic [DATA_W-1:0] LO_D  = DATA_W'(LO_VAL);

  logic              started;
  logic              fire;
  logic              send;
  logic              frame_first;
  logic              frame_last;
  logic [DATA_W-1:0] thr_now;
  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic              eof_p1;
  logic              unused_inputs;

  function automatic logic [DATA_W-1:0] classify(input logic [DATA_W-1:0] pix,
                                                 input logic [DATA_W-1:0] thr);
    if (pix >= thr) return (MODE == MODE_TOZERO) ? pix : HI_D;
    return (MODE == MODE_TOZERO) ? '0 : LO_D;
  endfunction

  // A new token may enter when the slot is empty or is being drained this edge.
  assign fire = started & In1_SEND & (~vld_p1 | Out1_RDY);
  assign send = vld_p1 & Out1_RDY;

  ripl_frame_counter #(
    .FRAME_PIXELS(FRAME_PIXELS)
  ) u_frame_counter (
    .CLK  (CLK),
    .RESET(RESET),
    .en   (fire),
    .first(frame_first),
    .last (frame_last)
  );

`ifdef RIPL_RUNTIME_THRESH_EN
  logic [DATA_W-1:0] active_thr;
  logic [DATA_W-1:0] pend_thr;
  logic              pend_vld;

  assign Thr_ACK = started & Thr_SEND & ~pend_vld;
  // A pending threshold only takes over on the frame-start token itself.
  assign thr_now = (pend_vld & frame_first) ? pend_thr : active_thr;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      active_thr <= THR_D;
      pend_thr   <= '0;
      pend_vld   <= 1'b0;
    end else if (fire & frame_first & pend_vld) begin
      active_thr <= pend_thr;
      pend_vld   <= 1'b0;
    end else if (Thr_ACK) begin
      pend_thr <= Thr_DATA;
      pend_vld <= 1'b1;
    end
  end
`else
  assign thr_now = THR_D;
`endif

  // Stage p1: classified pixel register with its valid and EOF tag
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      started <= 1'b0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      eof_p1  <= 1'b0;
    end else begin
      started <= 1'b1;
      if (fire) begin
        vld_p1  <= 1'b1;
        data_p1 <= classify(In1_DATA, thr_now);
        eof_p1  <= frame_last;
      end else if (send) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign In1_ACK    = fire;
  assign Out1_SEND  = send;
  assign Out1_DATA  = data_p1;
  assign Out1_EOF   = eof_p1;
  assign Out1_COUNT = UNIT_COUNT;

  assign unused_inputs = ^{In1_COUNT, Out1_ACK};

endmodule

// File: tb/tb_ripl_threshold_stream.sv
// Bench for ripl_threshold_stream: binary and to-zero instances against a token-queue model.
module tb_ripl_threshold_stream;

  localparam int DW  = 8;
  localparam int THR = 128;
  localparam int FP  = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [DW-1:0] In1_DATA;
  logic          In1_SEND;
  logic [15:0]   In1_COUNT;
  logic          Out1_RDY;
  logic          Out1_ACK;
  logic          ack0, send0, eof0, ack1, send1, eof1;
  logic [DW-1:0] data0, data1;
  logic [15:0]   cnt0, cnt1;
`ifdef RIPL_RUNTIME_THRESH_EN
  logic [DW-1:0] Thr_DATA;
  logic          Thr_SEND;
  logic          thr_ack0, thr_ack1;
`endif

  always #5 CLK = ~CLK;

  ripl_threshold_stream #(.DATA_W(DW), .THRESH(THR), .MODE(0), .FRAME_PIXELS(FP)) dut0 (
    .CLK(CLK), .RESET(RESET), .In1_DATA(In1_DATA), .In1_SEND(In1_SEND), .In1_COUNT(In1_COUNT),
    .In1_ACK(ack0), .Out1_DATA(data0), .Out1_SEND(send0), .Out1_RDY(Out1_RDY), .Out1_ACK(Out1_ACK),
    .Out1_COUNT(cnt0), .Out1_EOF(eof0)
`ifdef RIPL_RUNTIME_THRESH_EN
    , .Thr_DATA(Thr_DATA), .Thr_SEND(Thr_SEND), .Thr_ACK(thr_ack0)
`endif
  );

  ripl_threshold_stream #(.DATA_W(DW), .THRESH(THR), .MODE(1), .FRAME_PIXELS(FP)) dut1 (
    .CLK(CLK), .RESET(RESET), .In1_DATA(In1_DATA), .In1_SEND(In1_SEND), .In1_COUNT(In1_COUNT),
    .In1_ACK(ack1), .Out1_DATA(data1), .Out1_SEND(send1), .Out1_RDY(Out1_RDY), .Out1_ACK(Out1_ACK),
    .Out1_COUNT(cnt1), .Out1_EOF(eof1)
`ifdef RIPL_RUNTIME_THRESH_EN
    , .Thr_DATA(Thr_DATA), .Thr_SEND(Thr_SEND), .Thr_ACK(thr_ack1)
`endif
  );

  typedef struct {
    logic [DW-1:0] pix;
    logic [DW-1:0] thr;
    logic          eof;
  } tok_t;

  tok_t          m_q[$];
  int            m_idx;
  bit            m_started;
  logic [DW-1:0] m_thr;
  logic [DW-1:0] m_pend;
  bit            m_pend_vld;
  int            errors = 0;
  int            checks = 0;

  function automatic logic [DW-1:0] ref_out(input int mode, input logic [DW-1:0] pix,
                                            input logic [DW-1:0] thr);
    if (pix >= thr) return (mode == 1) ? pix : 8'd255;
    return 8'd0;
  endfunction

  function automatic bit exp_ack();
    return m_started && In1_SEND && (m_q.size() == 0 || Out1_RDY);
  endfunction

  function automatic bit exp_send();
    return (m_q.size() != 0) && Out1_RDY;
  endfunction

`ifdef RIPL_RUNTIME_THRESH_EN
  function automatic bit exp_thr_ack();
    return m_started && Thr_SEND && !m_pend_vld;
  endfunction
`endif

  task automatic model_reset();
    m_q.delete();
    m_idx      = 0;
    m_started  = 0;
    m_thr      = THR;
    m_pend     = '0;
    m_pend_vld = 0;
  endtask

  // Update the model with what the current inputs imply, then step one clock.
  task automatic advance();
    bit   f, s, ta;
    tok_t t;
    if (RESET) begin
      model_reset();
    end else begin
      f  = exp_ack();
      s  = exp_send();
      ta = 0;
`ifdef RIPL_RUNTIME_THRESH_EN
      ta = exp_thr_ack();
`endif
      if (s) void'(m_q.pop_front());
      if (f) begin
        t.pix = In1_DATA;
        t.thr = m_thr;
        if (m_idx == 0 && m_pend_vld) begin
          t.thr      = m_pend;
          m_thr      = m_pend;
          m_pend_vld = 0;
        end
        t.eof = (m_idx == FP - 1);
        m_q.push_back(t);
        m_idx = (m_idx + 1) % FP;
      end
`ifdef RIPL_RUNTIME_THRESH_EN
      if (ta) begin
        m_pend     = Thr_DATA;
        m_pend_vld = 1;
      end
`endif
      m_started = 1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET    = 1'b1;
    In1_SEND = 1'b0;
    Out1_RDY = 1'b1;
    model_reset();
    repeat (2) advance();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET    = 1'b1;
    In1_SEND = 1'b1;
    Out1_RDY = 1'b1;
    In1_DATA = 8'd200;
    model_reset();
    repeat (2) advance();
    @(negedge CLK);
    checks += 5;
    if (send0 !== 1'b0) begin errors++; $display("FAIL reset_send: got %b want 0", send0); end
    if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack0); end
    if (data0 !== 8'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", data0); end
    if (eof0 !== 1'b0) begin errors++; $display("FAIL reset_eof: got %b want 0", eof0); end
    if (cnt0 !== 16'd1) begin errors++; $display("FAIL out_count: got %0d want 1", cnt0); end
    advance();
    RESET = 1'b0;
    @(negedge CLK);
    checks += 2;
    if (ack0 !== 1'b0) begin errors++; $display("FAIL first_cycle_ack: got %b want 0", ack0); end
    if (send0 !== 1'b0) begin errors++; $display("FAIL first_cycle_send: got %b want 0", send0); end
    advance();
    @(negedge CLK);
    checks += 2;
    if (ack0 !== 1'b1) begin errors++; $display("FAIL second_cycle_ack: got %b want 1", ack0); end
    if (send0 !== 1'b0) begin errors++; $display("FAIL second_cycle_send: got %b want 0", send0); end
    advance();
    @(negedge CLK);
    checks += 3;
    if (send0 !== 1'b1) begin errors++; $display("FAIL first_send: got %b want 1", send0); end
    if (data0 !== 8'd255) begin errors++; $display("FAIL first_data: got %0d want 255", data0); end
    if (cnt1 !== 16'd1) begin errors++; $display("FAIL out_count_mode1: got %0d want 1", cnt1); end
    In1_SEND = 1'b0;
    repeat (3) advance();
  endtask

  task automatic test_binary_stream();
    logic [DW-1:0] ins[4];
    logic [DW-1:0] exp0[4];
    logic [DW-1:0] exp1[4];
    ins  = '{8'd127, 8'd128, 8'd255, 8'd0};
    exp0 = '{8'd0, 8'd255, 8'd255, 8'd0};
    exp1 = '{8'd0, 8'd128, 8'd255, 8'd0};
    Out1_RDY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin In1_SEND = 1'b1; In1_DATA = ins[i]; end
      else In1_SEND = 1'b0;
      @(negedge CLK);
      if (i < 4) begin
        checks++;
        if (ack0 !== 1'b1) begin errors++; $display("FAIL bin_ack[%0d]: got %b want 1", i, ack0); end
      end
      if (i >= 1) begin
        checks += 3;
        if (send0 !== 1'b1) begin errors++; $display("FAIL bin_send[%0d]: got %b want 1", i, send0); end
        if (data0 !== exp0[i-1]) begin errors++; $display("FAIL bin_data[%0d]: got %0d want %0d", i, data0, exp0[i-1]); end
        if (data1 !== exp1[i-1]) begin errors++; $display("FAIL tz_data[%0d]: got %0d want %0d", i, data1, exp1[i-1]); end
      end
      advance();
    end
    advance();
  endtask

  task automatic test_tozero();
    logic [DW-1:0] ins[2];
    logic [DW-1:0] exp1[2];
    ins  = '{8'd100, 8'd200};
    exp1 = '{8'd0, 8'd200};
    Out1_RDY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin In1_SEND = 1'b1; In1_DATA = ins[i]; end
      else In1_SEND = 1'b0;
      @(negedge CLK);
      if (i >= 1) begin
        checks += 2;
        if (send1 !== 1'b1) begin errors++; $display("FAIL tozero_send[%0d]: got %b want 1", i, send1); end
        if (data1 !== exp1[i-1]) begin errors++; $display("FAIL tozero_data[%0d]: got %0d want %0d", i, data1, exp1[i-1]); end
      end
      advance();
    end
    advance();
  endtask

  task automatic test_backpressure();
    Out1_RDY = 1'b1;
    In1_SEND = 1'b1;
    In1_DATA = 8'd200;
    @(negedge CLK);
    checks++;
    if (ack0 !== 1'b1) begin errors++; $display("FAIL bp_fill_ack: got %b want 1", ack0); end
    advance();
    In1_DATA = 8'd10;
    Out1_RDY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checks += 4;
      if (ack0 !== 1'b0) begin errors++; $display("FAIL bp_stall_ack[%0d]: got %b want 0", i, ack0); end
      if (send0 !== 1'b0) begin errors++; $display("FAIL bp_stall_send[%0d]: got %b want 0", i, send0); end
      if (data0 !== 8'd255) begin errors++; $display("FAIL bp_hold_data[%0d]: got %0d want 255", i, data0); end
      if (data1 !== 8'd200) begin errors++; $display("FAIL bp_hold_tz[%0d]: got %0d want 200", i, data1); end
      advance();
    end
    Out1_RDY = 1'b1;
    @(negedge CLK);
    checks += 3;
    if (send0 !== 1'b1) begin errors++; $display("FAIL bp_release_send: got %b want 1", send0); end
    if (ack0 !== 1'b1) begin errors++; $display("FAIL bp_refill_ack: got %b want 1", ack0); end
    if (data0 !== 8'd255) begin errors++; $display("FAIL bp_release_data: got %0d want 255", data0); end
    advance();
    In1_SEND = 1'b0;
    @(negedge CLK);
    checks += 3;
    if (send0 !== 1'b1) begin errors++; $display("FAIL bp_next_send: got %b want 1", send0); end
    if (data0 !== 8'd0) begin errors++; $display("FAIL bp_next_data: got %0d want 0", data0); end
    if (data1 !== 8'd0) begin errors++; $display("FAIL bp_next_tz: got %0d want 0", data1); end
    repeat (2) advance();
  endtask

  task automatic test_frame_eof();
    int acc, tok;
    do_reset();
    acc = 0;
    tok = 0;
    Out1_RDY = 1'b1;
    for (int c = 0; c < 14; c++) begin
      In1_SEND = (acc < 9);
      In1_DATA = 8'($urandom);
      @(negedge CLK);
      if (exp_ack()) acc++;
      checks++;
      if (send0 !== exp_send()) begin errors++; $display("FAIL eof_send[%0d]: got %b want %b", c, send0, exp_send()); end
      if (send0 === 1'b1) begin
        tok++;
        checks += 2;
        if (eof0 !== (tok == 4 || tok == 8)) begin errors++; $display("FAIL eof_tok%0d: got %b want %b", tok, eof0, (tok == 4 || tok == 8)); end
        if (eof1 !== (tok == 4 || tok == 8)) begin errors++; $display("FAIL eof_tz_tok%0d: got %b want %b", tok, eof1, (tok == 4 || tok == 8)); end
      end
      advance();
    end
    checks++;
    if (tok !== 9) begin errors++; $display("FAIL eof_token_total: got %0d want 9", tok); end
  endtask

  task automatic test_reset_midframe();
    int acc, tok;
    do_reset();
    advance();
    Out1_RDY = 1'b1;
    In1_SEND = 1'b1;
    In1_DATA = 8'd150;
    repeat (2) advance();
    In1_SEND = 1'b0;
    @(negedge CLK);
    checks++;
    if (send0 !== 1'b1) begin errors++; $display("FAIL mid_presend: got %b want 1", send0); end
    #1;
    RESET = 1'b1;
    model_reset();
    #1;
    checks += 4;
    if (send0 !== 1'b0) begin errors++; $display("FAIL mid_reset_send: got %b want 0", send0); end
    if (data0 !== 8'd0) begin errors++; $display("FAIL mid_reset_data: got %0d want 0", data0); end
    if (eof0 !== 1'b0) begin errors++; $display("FAIL mid_reset_eof: got %b want 0", eof0); end
    if (ack0 !== 1'b0) begin errors++; $display("FAIL mid_reset_ack: got %b want 0", ack0); end
    advance();
    RESET = 1'b0;
    acc = 0;
    tok = 0;
    for (int c = 0; c < 9; c++) begin
      In1_SEND = (acc < 5);
      In1_DATA = 8'($urandom);
      @(negedge CLK);
      if (exp_ack()) acc++;
      if (send0 === 1'b1) begin
        tok++;
        checks++;
        if (eof0 !== (tok == 4)) begin errors++; $display("FAIL mid_eof_tok%0d: got %b want %b", tok, eof0, (tok == 4)); end
      end
      advance();
    end
    checks++;
    if (tok !== 5) begin errors++; $display("FAIL mid_token_total: got %0d want 5", tok); end
  endtask

`ifdef RIPL_RUNTIME_THRESH_EN
  task automatic test_runtime_thresh();
    logic [DW-1:0] exp0[6];
    logic [DW-1:0] exp1[6];
    int  acc, tok;
    bit  thr_done;
    exp0 = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0};
    exp1 = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd60, 8'd0};
    do_reset();
    advance();
    acc = 0;
    tok = 0;
    thr_done = 0;
    Out1_RDY = 1'b1;
    for (int c = 0; c < 14; c++) begin
      Thr_SEND = 1'b0;
      In1_SEND = 1'b0;
      if (acc == 2 && !thr_done) begin
        Thr_SEND = 1'b1;
        Thr_DATA = 8'd50;
      end else if (acc < 6) begin
        In1_SEND = 1'b1;
        In1_DATA = (acc == 5) ? 8'd40 : 8'd60;
      end
      @(negedge CLK);
      if (Thr_SEND) begin
        checks++;
        if (thr_ack0 !== 1'b1) begin errors++; $display("FAIL thr_ack: got %b want 1", thr_ack0); end
        thr_done = 1;
      end
      if (exp_ack()) acc++;
      if (send0 === 1'b1 && tok < 6) begin
        checks += 2;
        if (data0 !== exp0[tok]) begin errors++; $display("FAIL thr_bin_tok%0d: got %0d want %0d", tok + 1, data0, exp0[tok]); end
        if (data1 !== exp1[tok]) begin errors++; $display("FAIL thr_tz_tok%0d: got %0d want %0d", tok + 1, data1, exp1[tok]); end
        tok++;
      end
      advance();
    end
    Thr_SEND = 1'b0;
    checks++;
    if (tok !== 6) begin errors++; $display("FAIL thr_token_total: got %0d want 6", tok); end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      In1_SEND = ($urandom_range(0, 3) != 0);
      Out1_RDY = ($urandom_range(0, 2) != 0);
      In1_DATA = 8'($urandom);
`ifdef RIPL_RUNTIME_THRESH_EN
      Thr_SEND = ($urandom_range(0, 15) == 0);
      Thr_DATA = 8'($urandom);
`endif
      @(negedge CLK);
      checks += 4;
      if (ack0 !== exp_ack()) begin errors++; $display("FAIL rnd_ack0[%0d]: got %b want %b", c, ack0, exp_ack()); end
      if (ack1 !== exp_ack()) begin errors++; $display("FAIL rnd_ack1[%0d]: got %b want %b", c, ack1, exp_ack()); end
      if (send0 !== exp_send()) begin errors++; $display("FAIL rnd_send0[%0d]: got %b want %b", c, send0, exp_send()); end
      if (send1 !== exp_send()) begin errors++; $display("FAIL rnd_send1[%0d]: got %b want %b", c, send1, exp_send()); end
      if (m_q.size() != 0) begin
        checks += 3;
        if (data0 !== ref_out(0, m_q[0].pix, m_q[0].thr)) begin
          errors++; $display("FAIL rnd_data0[%0d]: got %0d want %0d", c, data0, ref_out(0, m_q[0].pix, m_q[0].thr));
        end
        if (data1 !== ref_out(1, m_q[0].pix, m_q[0].thr)) begin
          errors++; $display("FAIL rnd_data1[%0d]: got %0d want %0d", c, data1, ref_out(1, m_q[0].pix, m_q[0].thr));
        end
        if (eof0 !== m_q[0].eof) begin errors++; $display("FAIL rnd_eof[%0d]: got %b want %b", c, eof0, m_q[0].eof); end
      end
`ifdef RIPL_RUNTIME_THRESH_EN
      checks++;
      if (thr_ack0 !== exp_thr_ack()) begin errors++; $display("FAIL rnd_thr_ack[%0d]: got %b want %b", c, thr_ack0, exp_thr_ack()); end
`endif
      advance();
    end
`ifdef RIPL_RUNTIME_THRESH_EN
    Thr_SEND = 1'b0;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET     = 1'b1;
    In1_DATA  = '0;
    In1_SEND  = 1'b0;
    In1_COUNT = 16'd1;
    Out1_RDY  = 1'b1;
    Out1_ACK  = 1'b0;
`ifdef RIPL_RUNTIME_THRESH_EN
    Thr_DATA = '0;
    Thr_SEND = 1'b0;
`endif
    model_reset();
    test_reset();
    test_binary_stream();
    test_tozero();
    test_backpressure();
    test_frame_eof();
    test_reset_midframe();
`ifdef RIPL_RUNTIME_THRESH_EN
    test_runtime_thresh();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
